// File: rtl/leb128_uint32_encode_stream.sv
// leb128_uint32_encode_stream: byte-serial LEB128 encoder for 32-bit words, MIN_BYTES pads with continuation bytes.
// Define LEB128_SIGNED_EN to add the in_signed port and SLEB128 encoding.
module leb128_uint32_encode_stream #(
    parameter int MIN_BYTES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
`ifdef LEB128_SIGNED_EN
    input  logic        in_signed,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic [2:0]  out_idx
);
    typedef enum logic {IDLE, EMIT} state_e;

    state_e      state_q, state_d;
    logic [31:0] sh_q, sh_d;
    logic [2:0]  idx_q, idx_d;
    logic        sgn_q, sgn_d;
    logic        sgn_in, emit, pad, done, cont, load;
    logic [31:0] rest, rest_s;

`ifdef LEB128_SIGNED_EN
    assign sgn_in = in_signed;
`else
    assign sgn_in = 1'b0;
`endif

    // rest_s is computed on its own so the arithmetic shift is not demoted by an unsigned ternary
    assign rest_s = $signed(sh_q) >>> 7;
    assign rest   = sgn_q ? rest_s : sh_q >> 7;
    assign done   = sgn_q ? ((rest == '0 & ~sh_q[6]) | (&rest & sh_q[6])) : rest == '0;
    assign pad    = (int'(idx_q) + 1) < MIN_BYTES;
    assign cont   = (idx_q != 3'd4) & (pad | ~done);
    assign emit   = state_q == EMIT;

    assign out_valid = emit;
    assign out_data  = emit ? {cont, sh_q[6:0]} : 8'h00;
    assign out_last  = emit & ~cont;
    assign out_idx   = emit ? idx_q + 3'd1 : 3'd0;
    assign in_ready  = rst_n & (~emit | (out_ready & ~cont));
    assign load      = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        idx_d   = idx_q;
        sgn_d   = sgn_q;
        if (emit & out_ready & cont) begin
            sh_d  = rest;
            idx_d = idx_q + 3'd1;
        end else if (emit & out_ready) begin
            state_d = IDLE;
        end
        if (load) begin
            state_d = EMIT;
            sh_d    = in_data;
            idx_d   = 3'd0;
            sgn_d   = sgn_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            idx_q   <= '0;
            sgn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
            sgn_q   <= sgn_d;
        end
    end
endmodule

// File: tb/tb_leb128_uint32_encode_stream.sv
// tb_leb128_uint32_encode_stream: directed checks of three encoder instances (MIN_BYTES 1, 5, 3) sharing one input stream.
module tb_leb128_uint32_encode_stream;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_data = '0;
`ifdef LEB128_SIGNED_EN
    logic        in_signed = 1'b0;
`endif
    logic        ir [3];
    logic        ov [3];
    logic        ol [3];
    logic [7:0]  od [3];
    logic [2:0]  oi [3];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

`ifdef LEB128_SIGNED_EN
    `define SGN_PORT .in_signed(in_signed),
`else
    `define SGN_PORT
`endif

    leb128_uint32_encode_stream #(.MIN_BYTES(1)) u0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
        .in_data(in_data), `SGN_PORT .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_last(ol[0]), .out_idx(oi[0]));
    leb128_uint32_encode_stream #(.MIN_BYTES(5)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
        .in_data(in_data), `SGN_PORT .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_last(ol[1]), .out_idx(oi[1]));
    leb128_uint32_encode_stream #(.MIN_BYTES(3)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
        .in_data(in_data), `SGN_PORT .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .out_last(ol[2]), .out_idx(oi[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bchk(input int d, input string tag, input logic [7:0] b, input logic l, input logic [2:0] i);
        check($sformatf("%s.u%0d.valid", tag, d), 32'(ov[d]), 32'd1);
        check($sformatf("%s.u%0d.data", tag, d), 32'(od[d]), 32'(b));
        check($sformatf("%s.u%0d.last", tag, d), 32'(ol[d]), 32'(l));
        check($sformatf("%s.u%0d.idx", tag, d), 32'(oi[d]), 32'(i));
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((ov[0] | ov[1] | ov[2]) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(n < 40), 32'd1);
    endtask

    logic [7:0] e1 [5] = '{8'hAC, 8'h82, 8'h80, 8'h80, 8'h00};
    logic [7:0] e2 [3] = '{8'hAC, 8'h82, 8'h00};
    logic [7:0] e0 [2] = '{8'hAC, 8'h02};

    initial begin
        repeat (2) @(negedge clk);
        check("rst.valid", 32'(ov[0]), 0);
        check("rst.data", 32'(od[0]), 0);
        check("rst.last", 32'(ol[0]), 0);
        check("rst.idx", 32'(oi[0]), 0);
        check("rst.ready", 32'(ir[0]), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle.ready", 32'(ir[0]), 1);
        // zero: single byte on MIN_BYTES=1, padded on MIN_BYTES=5
        in_valid = 1'b1; in_data = 32'd0;
        @(negedge clk);
        in_valid = 1'b0;
        bchk(0, "zero", 8'h00, 1'b1, 3'd1);
        check("zero.ready", 32'(ir[0]), 1);
        bchk(1, "zero", 8'h80, 1'b0, 3'd1);
        wait_idle();
        // 624485 -> E5 8E 26
        in_valid = 1'b1; in_data = 32'd624485;
        @(negedge clk);
        in_valid = 1'b0;
        bchk(0, "w624485", 8'hE5, 1'b0, 3'd1);
        @(negedge clk);
        bchk(0, "w624485", 8'h8E, 1'b0, 3'd2);
        @(negedge clk);
        bchk(0, "w624485", 8'h26, 1'b1, 3'd3);
        wait_idle();
        // all-ones then 300 back-to-back on the final byte
        in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            in_data = 32'd300;
            bchk(0, "ones", 8'hFF, 1'b0, 3'(k));
        end
        @(negedge clk);
        bchk(0, "ones", 8'h0F, 1'b1, 3'd5);
        check("ones.b2b_ready", 32'(ir[0]), 1);
        bchk(2, "ones", 8'h0F, 1'b1, 3'd5);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            bchk(1, "w300", e1[k], k == 4, 3'(k + 1));
            if (k < 3) bchk(2, "w300", e2[k], k == 2, 3'(k + 1));
            if (k < 2) bchk(0, "w300", e0[k], k == 1, 3'(k + 1));
        end
        wait_idle();
        // 1 padded to five bytes
        in_valid = 1'b1; in_data = 32'd1;
        @(negedge clk);
        in_valid = 1'b0;
        bchk(0, "one", 8'h01, 1'b1, 3'd1);
        bchk(1, "one", 8'h81, 1'b0, 3'd1);
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            bchk(1, "one", k == 5 ? 8'h00 : 8'h80, k == 5, 3'(k));
        end
        wait_idle();
        // stall then async reset with a byte pending
        in_valid = 1'b1; in_data = 32'd300; out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            bchk(0, "stall", 8'hAC, 1'b0, 3'd1);
            check("stall.ready", 32'(ir[0]), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        bchk(0, "stall", 8'h02, 1'b1, 3'd2);
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst.valid", 32'(ov[0]), 0);
        check("arst.data", 32'(od[0]), 0);
        check("arst.ready", 32'(ir[0]), 0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'd5;
        @(negedge clk);
        in_valid = 1'b0;
        bchk(0, "post_rst", 8'h05, 1'b1, 3'd1);
        wait_idle();
`ifdef LEB128_SIGNED_EN
        in_valid = 1'b1; in_signed = 1'b1; in_data = 32'hFFFE_1DC0;
        @(negedge clk);
        in_valid = 1'b0;
        bchk(0, "sneg", 8'hC0, 1'b0, 3'd1);
        @(negedge clk);
        bchk(0, "sneg", 8'hBB, 1'b0, 3'd2);
        @(negedge clk);
        bchk(0, "sneg", 8'h78, 1'b1, 3'd3);
        wait_idle();
        in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
        @(negedge clk);
        in_valid = 1'b0;
        bchk(0, "sm1", 8'h7F, 1'b1, 3'd1);
        bchk(1, "sm1", 8'hFF, 1'b0, 3'd1);
        wait_idle();
        in_valid = 1'b1; in_data = 32'd63;
        @(negedge clk);
        in_valid = 1'b0;
        bchk(0, "s63", 8'h3F, 1'b1, 3'd1);
        wait_idle();
        in_valid = 1'b1; in_data = 32'd64;
        @(negedge clk);
        in_valid = 1'b0;
        bchk(0, "s64", 8'hC0, 1'b0, 3'd1);
        @(negedge clk);
        bchk(0, "s64", 8'h00, 1'b1, 3'd2);
        wait_idle();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
